// File: rtl/bratcr_ctrl.sv
// ---------------------------------------------------------------------------
// bratcr_ctrl
//   Bookkeeping for the Branch RAT Copy Register checkpoints. Hands out
//   checkpoint slots to branches renamed in ID (all-or-nothing per cycle),
//   frees them in order at retire, and on a mispredict truncates the table
//   to the mispredicted branch and sequences the FRAT restore from its
//   checkpoint, RESTORE_PER_CYC RAT entries per cycle.
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   br_val_id            per rename slot: branch needs a checkpoint
//   br_robid_id          per rename slot: ROB id of that branch
//   alloc_stall_id       rename must hold this cycle
//   ckpt_wr_en/_idx      per slot FRAT snapshot write enable and target entry
//   br_ret_val/_robid    oldest branch retiring and its ROB id
//   mispredict_val/_robid  mispredicted branch and its ROB id
//   flush                drop every checkpoint, no restore
//   restore_act          restore sequence running
//   restore_ckpt_idx     checkpoint being copied into the RAT
//   restore_base         first RAT index written this cycle
//   restore_done         one-cycle pulse when the restore finishes
//   mispr_miss           mispredict ROB id had no valid checkpoint
//   ret_miss             retire on empty table or head ROB id mismatch
//   ckpt_cnt             occupied checkpoint entries
//
// FSM states
//   state      | meaning
//   ST_IDLE    | normal operation, allocation allowed
//   ST_RESTORE | copying checkpoint restore_idx into the RAT
//   ST_DONE    | restore finished, pulse restore_done, still stalling rename
// ---------------------------------------------------------------------------
module bratcr_ctrl #(
    parameter int ISSUE_WIDTH_MAX     = 2,
    parameter int ROB_SIZE_CLOG       = 6,
    parameter int BRATCR_NUM_ETY      = 4,
    parameter int BRATCR_NUM_ETY_CLOG = 2,
    parameter int RAT_SIZE            = 32,
    parameter int RESTORE_PER_CYC     = 8,
    localparam int RAT_IDX_W          = $clog2(RAT_SIZE),
    localparam int IDX_W              = BRATCR_NUM_ETY_CLOG,
    localparam int CNT_W              = BRATCR_NUM_ETY_CLOG + 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [ISSUE_WIDTH_MAX-1:0]                   br_val_id,
    input  logic [ISSUE_WIDTH_MAX-1:0][ROB_SIZE_CLOG-1:0] br_robid_id,
    output logic                                         alloc_stall_id,
    output logic [ISSUE_WIDTH_MAX-1:0]                   ckpt_wr_en,
    output logic [ISSUE_WIDTH_MAX-1:0][IDX_W-1:0]        ckpt_wr_idx,
    input  logic                                         br_ret_val,
    input  logic [ROB_SIZE_CLOG-1:0]                     br_ret_robid,
    input  logic                                         mispredict_val,
    input  logic [ROB_SIZE_CLOG-1:0]                     mispredict_robid,
    input  logic                                         flush,
    output logic                                         restore_act,
    output logic [IDX_W-1:0]                             restore_ckpt_idx,
    output logic [RAT_IDX_W-1:0]                         restore_base,
    output logic                                         restore_done,
    output logic                                         mispr_miss,
    output logic                                         ret_miss,
    output logic [CNT_W-1:0]                             ckpt_cnt
);

    localparam logic [RAT_IDX_W-1:0] RESTORE_STEP = RAT_IDX_W'(RESTORE_PER_CYC);
    localparam logic [RAT_IDX_W-1:0] LAST_BASE    = RAT_IDX_W'(RAT_SIZE - RESTORE_PER_CYC);
    localparam logic [CNT_W-1:0]     NUM_ETY      = CNT_W'(BRATCR_NUM_ETY);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTORE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                                     state_q, state_d;
    logic [BRATCR_NUM_ETY-1:0]                  valid_q, valid_d;
    logic [BRATCR_NUM_ETY-1:0][ROB_SIZE_CLOG-1:0] robid_q, robid_d;
    logic [IDX_W-1:0]                           head_q, head_d;
    logic [IDX_W-1:0]                           tail_q, tail_d;
    logic [CNT_W-1:0]                           cnt_q, cnt_d;
    logic [RAT_IDX_W-1:0]                       restore_ptr_q, restore_ptr_d;
    logic [IDX_W-1:0]                           restore_idx_q, restore_idx_d;

    logic             busy;
    logic [CNT_W-1:0] need;
    logic [CNT_W-1:0] free_slots;
    logic             stall_raw;
    logic             alloc_go;
    logic [CNT_W-1:0] alloc_count;
    logic [IDX_W-1:0] slot_ofs;

    logic             ret_free;

    logic             mis_hit;
    logic [IDX_W-1:0] mis_idx;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] mis_age;
    logic [IDX_W-1:0] cur_age;
    logic             mis_accept;
    logic [IDX_W-1:0] ent_age;

    assign busy       = (state_q != ST_IDLE);
    assign free_slots = NUM_ETY - cnt_q;

    always_comb begin
        need = '0;
        for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            need = need + CNT_W'(br_val_id[i]);
        end
    end

    // Combinational outputs are qualified with rst so that everything reads
    // 0 while reset is held, whatever the inputs are doing.
    assign stall_raw      = (need > free_slots) | busy | mispredict_val | flush;
    assign alloc_stall_id = rst & stall_raw;
    assign alloc_go       = rst & ~stall_raw & (need != '0);
    assign alloc_count    = alloc_go ? need : '0;

    // k-th requesting slot (in slot order) lands at tail+k.
    always_comb begin
        ckpt_wr_en  = '0;
        ckpt_wr_idx = '0;
        slot_ofs    = '0;
        for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            if (br_val_id[i]) begin
                if (alloc_go) begin
                    ckpt_wr_en[i]  = 1'b1;
                    ckpt_wr_idx[i] = tail_q + slot_ofs;
                end
                slot_ofs = slot_ofs + IDX_W'(1);
            end
        end
    end

    assign ret_free = br_ret_val & ~flush & valid_q[head_q] &
                      (robid_q[head_q] == br_ret_robid);
    assign ret_miss = rst & br_ret_val & ~flush & ~ret_free;

    // CAM scan from youngest to oldest so the oldest match wins if a ROB id
    // ever appears twice.
    always_comb begin
        mis_hit  = 1'b0;
        mis_idx  = '0;
        scan_idx = '0;
        for (int a = BRATCR_NUM_ETY - 1; a >= 0; a--) begin
            scan_idx = head_q + IDX_W'(a);
            if (valid_q[scan_idx] && (robid_q[scan_idx] == mispredict_robid)) begin
                mis_hit = 1'b1;
                mis_idx = scan_idx;
            end
        end
    end

    assign mis_age = mis_idx - head_q;
    assign cur_age = restore_idx_q - head_q;

    // While a restore is already running only a strictly older branch can
    // take over; anything else (same entry, younger, no match) is dropped
    // silently because the running restore already covers it.
    assign mis_accept = mispredict_val & ~flush & mis_hit &
                        (~busy | (mis_age < cur_age));
    assign mispr_miss = rst & mispredict_val & ~flush & ~mis_hit & ~busy;

    always_comb begin
        valid_d = valid_q;
        robid_d = robid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        ent_age = '0;
        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            cnt_d   = '0;
        end else begin
            if (ret_free) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + IDX_W'(1);
            end
            if (mis_accept) begin
                for (int i = 0; i < BRATCR_NUM_ETY; i++) begin
                    ent_age = IDX_W'(i) - head_q;
                    if (ent_age > mis_age) begin
                        valid_d[i] = 1'b0;
                    end
                end
                tail_d = mis_idx + IDX_W'(1);
                cnt_d  = CNT_W'(mis_age) + CNT_W'(1) - CNT_W'(ret_free);
            end else begin
                for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
                    if (ckpt_wr_en[i]) begin
                        valid_d[ckpt_wr_idx[i]] = 1'b1;
                        robid_d[ckpt_wr_idx[i]] = br_robid_id[i];
                    end
                end
                tail_d = tail_q + IDX_W'(alloc_count);
                cnt_d  = cnt_q + alloc_count - CNT_W'(ret_free);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        restore_ptr_d    = restore_ptr_q;
        restore_idx_d    = restore_idx_q;
        restore_act      = 1'b0;
        restore_done     = 1'b0;
        restore_ckpt_idx = '0;
        restore_base     = '0;
        case (state_q)
            ST_RESTORE: begin
                restore_act      = 1'b1;
                restore_ckpt_idx = restore_idx_q;
                restore_base     = restore_ptr_q;
                restore_ptr_d    = restore_ptr_q + RESTORE_STEP;
                if (restore_ptr_q == LAST_BASE) begin
                    state_d       = ST_DONE;
                    restore_ptr_d = '0;
                end
            end
            ST_DONE: begin
                restore_done = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (mis_accept) begin
            state_d       = ST_RESTORE;
            restore_ptr_d = '0;
            restore_idx_d = mis_idx;
        end
        if (flush) begin
            state_d       = ST_IDLE;
            restore_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= '0;
            robid_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            cnt_q         <= '0;
            restore_ptr_q <= '0;
            restore_idx_q <= '0;
        end else begin
            valid_q       <= valid_d;
            robid_q       <= robid_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            cnt_q         <= cnt_d;
            restore_ptr_q <= restore_ptr_d;
            restore_idx_q <= restore_idx_d;
        end
    end

    assign ckpt_cnt = cnt_q;

endmodule

// File: tb/tb_bratcr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bratcr_ctrl
//   Self-checking bench for bratcr_ctrl. The reference keeps the live
//   checkpoints as an in-order queue of ROB ids (oldest first) plus the
//   physical index of the oldest one; slot indices, ages and counts are
//   derived from queue positions. Directed sequences come first, then a
//   randomized run.
// ---------------------------------------------------------------------------
module tb_bratcr_ctrl;

    localparam int IW    = 2;
    localparam int N     = 4;
    localparam int STEPS = 32 / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      br_val_id;
    logic [1:0][5:0] br_robid_id;
    logic            alloc_stall_id;
    logic [1:0]      ckpt_wr_en;
    logic [1:0][1:0] ckpt_wr_idx;
    logic            br_ret_val;
    logic [5:0]      br_ret_robid;
    logic            mispredict_val;
    logic [5:0]      mispredict_robid;
    logic            flush;
    logic            restore_act;
    logic [1:0]      restore_ckpt_idx;
    logic [4:0]      restore_base;
    logic            restore_done;
    logic            mispr_miss;
    logic            ret_miss;
    logic [2:0]      ckpt_cnt;

    bratcr_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .br_val_id        (br_val_id),
        .br_robid_id      (br_robid_id),
        .alloc_stall_id   (alloc_stall_id),
        .ckpt_wr_en       (ckpt_wr_en),
        .ckpt_wr_idx      (ckpt_wr_idx),
        .br_ret_val       (br_ret_val),
        .br_ret_robid     (br_ret_robid),
        .mispredict_val   (mispredict_val),
        .mispredict_robid (mispredict_robid),
        .flush            (flush),
        .restore_act      (restore_act),
        .restore_ckpt_idx (restore_ckpt_idx),
        .restore_base     (restore_base),
        .restore_done     (restore_done),
        .mispr_miss       (mispr_miss),
        .ret_miss         (ret_miss),
        .ckpt_cnt         (ckpt_cnt)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // reference model
    int q_rob[$];
    int m_head;
    int m_mode;   // 0 idle, 1 restoring, 2 done pulse
    int m_step;
    int m_ridx;

    // per-cycle expectation / decisions
    bit          e_stall, e_rmiss, e_mmiss, go, ret_ok, accept;
    logic [1:0]  e_en;
    logic [3:0]  e_idx;
    int          hit_k;

    // sampled DUT outputs of the last driven cycle
    logic        o_stall, o_act, o_done, o_mmiss, o_rmiss;
    logic [1:0]  o_en, o_cidx;
    logic [3:0]  o_idx;
    logic [4:0]  o_base;
    logic [2:0]  o_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_rob.delete();
        m_head = 0;
        m_mode = 0;
        m_step = 0;
        m_ridx = 0;
    endtask

    task automatic model_expect(input logic [1:0] bv, input logic rv, input logic [5:0] rr,
                                input logic mv, input logic [5:0] mr, input logic fl);
        int n, need, k, r_age;
        bit busy;
        n     = q_rob.size();
        need  = int'(bv[0]) + int'(bv[1]);
        busy  = (m_mode != 0);
        e_stall = (need > N - n) || busy || mv || fl;
        go    = (need > 0) && !e_stall;
        e_en  = 2'b00;
        e_idx = 4'h0;
        k = 0;
        for (int i = 0; i < IW; i++) begin
            if (bv[i]) begin
                if (go) begin
                    e_en[i] = 1'b1;
                    e_idx[2*i +: 2] = 2'((m_head + n + k) % N);
                end
                k++;
            end
        end
        ret_ok  = rv && !fl && (n > 0) && (q_rob[0] == int'(rr));
        e_rmiss = rv && !fl && !ret_ok;
        hit_k = -1;
        if (mv) begin
            for (int j = n - 1; j >= 0; j--) begin
                if (q_rob[j] == int'(mr)) hit_k = j;
            end
        end
        r_age   = (m_ridx - m_head + N) % N;
        accept  = mv && !fl && (hit_k >= 0) && (!busy || hit_k < r_age);
        e_mmiss = mv && !fl && (hit_k < 0) && !busy;
    endtask

    task automatic model_update(input logic [1:0] bv, input logic [5:0] r0, input logic [5:0] r1,
                                input logic fl);
        if (fl) begin
            model_reset();
        end else begin
            if (accept) begin
                while (q_rob.size() > hit_k + 1) void'(q_rob.pop_back());
                m_mode = 1;
                m_step = 0;
                m_ridx = (m_head + hit_k) % N;
            end else begin
                if (m_mode == 1) begin
                    if (m_step == STEPS - 1) m_mode = 2;
                    else m_step++;
                end else if (m_mode == 2) begin
                    m_mode = 0;
                end
                if (go) begin
                    if (bv[0]) q_rob.push_back(int'(r0));
                    if (bv[1]) q_rob.push_back(int'(r1));
                end
            end
            if (ret_ok) begin
                void'(q_rob.pop_front());
                m_head = (m_head + 1) % N;
            end
        end
    endtask

    task automatic drive(input logic [1:0] bv, input logic [5:0] r0, input logic [5:0] r1,
                         input logic rv, input logic [5:0] rr,
                         input logic mv, input logic [5:0] mr, input logic fl);
        @(negedge clk);
        br_val_id        = bv;
        br_robid_id[0]   = r0;
        br_robid_id[1]   = r1;
        br_ret_val       = rv;
        br_ret_robid     = rr;
        mispredict_val   = mv;
        mispredict_robid = mr;
        flush            = fl;
        #1;
        o_stall = alloc_stall_id;
        o_en    = ckpt_wr_en;
        o_idx   = ckpt_wr_idx;
        o_cnt   = ckpt_cnt;
        o_act   = restore_act;
        o_cidx  = restore_ckpt_idx;
        o_base  = restore_base;
        o_done  = restore_done;
        o_mmiss = mispr_miss;
        o_rmiss = ret_miss;
        model_expect(bv, rv, rr, mv, mr, fl);
        chk("stall",    32'(o_stall), 32'(e_stall));
        chk("wr_en",    32'(o_en),    32'(e_en));
        chk("wr_idx",   32'(o_idx),   32'(e_idx));
        chk("cnt",      32'(o_cnt),   q_rob.size());
        chk("ret_miss", 32'(o_rmiss), 32'(e_rmiss));
        chk("mis_miss", 32'(o_mmiss), 32'(e_mmiss));
        chk("r_act",    32'(o_act),   32'(m_mode == 1));
        chk("r_done",   32'(o_done),  32'(m_mode == 2));
        chk("r_idx",    32'(o_cidx),  (m_mode == 1) ? m_ridx : 0);
        chk("r_base",   32'(o_base),  (m_mode == 1) ? m_step * 8 : 0);
        @(posedge clk);
        model_update(bv, r0, r1, fl);
    endtask

    task automatic idle();
        drive(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic do_flush();
        drive(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    endtask

    int nxt_rob = 0;

    initial begin
        logic [1:0] bv;
        logic [5:0] r0, r1, rr, mr;
        logic       rv, mv, fl;
        bit         found;

        rst = 1'b0;
        br_val_id = 2'b00;
        br_robid_id = '0;
        br_ret_val = 1'b1;
        br_ret_robid = 6'd0;
        mispredict_val = 1'b1;
        mispredict_robid = 6'd0;
        flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(alloc_stall_id), 0);
        chk("rst_cnt",   32'(ckpt_cnt),       0);
        chk("rst_act",   32'(restore_act),    0);
        chk("rst_rmiss", 32'(ret_miss),       0);
        chk("rst_mmiss", 32'(mispr_miss),     0);
        br_ret_val = 1'b0;
        mispredict_val = 1'b0;
        rst = 1'b1;

        // allocate two branches after reset
        drive(2'b11, 6'd5, 6'd6, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        chk("tp1_en",    32'(o_en),    32'h3);
        chk("tp1_idx",   32'(o_idx),   32'h4);
        chk("tp1_stall", 32'(o_stall), 0);
        idle();
        chk("tp1_cnt",   32'(o_cnt),   2);

        // full-ish stall with retire, then wrap
        drive(2'b01, 6'd7, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(2'b11, 6'd8, 6'd9, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0);
        chk("tp2_stall", 32'(o_stall), 1);
        chk("tp2_en",    32'(o_en),    0);
        chk("tp2_cnt",   32'(o_cnt),   3);
        drive(2'b11, 6'd8, 6'd9, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        chk("tp2_cnt2",  32'(o_cnt),   2);
        chk("tp2_idx",   32'(o_idx),   32'h3);
        chk("tp2_en2",   32'(o_en),    32'h3);
        idle();
        chk("tp2_full",  32'(o_cnt),   4);

        // mispredict with full restore sequence
        do_flush();
        drive(2'b11, 6'd10, 6'd11, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(2'b01, 6'd12, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd11, 1'b0);
        chk("tp3_stall", 32'(o_stall), 1);
        for (int j = 0; j < 4; j++) begin
            idle();
            chk("tp3_act",  32'(o_act),  1);
            chk("tp3_base", 32'(o_base), 32'(j * 8));
            chk("tp3_cidx", 32'(o_cidx), 1);
            chk("tp3_cnt",  32'(o_cnt),  2);
        end
        idle();
        chk("tp3_done",  32'(o_done),  1);
        chk("tp3_act0",  32'(o_act),   0);
        chk("tp3_dstl",  32'(o_stall), 1);
        idle();
        chk("tp3_free",  32'(o_stall), 0);
        chk("tp3_done0", 32'(o_done),  0);

        // nested mispredicts during a restore
        do_flush();
        drive(2'b11, 6'd20, 6'd21, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(2'b01, 6'd22, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd22, 1'b0);
        drive(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd21, 1'b0);
        chk("tp4_cidx2", 32'(o_cidx), 2);
        drive(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd23, 1'b0);
        chk("tp4_base0", 32'(o_base), 0);
        chk("tp4_cidx1", 32'(o_cidx), 1);
        chk("tp4_nomiss", 32'(o_mmiss), 0);
        drive(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd21, 1'b0);
        chk("tp4_base8", 32'(o_base), 8);
        repeat (4) idle();

        // misses
        do_flush();
        drive(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd40, 1'b0);
        chk("tp5_mmiss", 32'(o_mmiss), 1);
        idle();
        chk("tp5_mmiss0", 32'(o_mmiss), 0);
        chk("tp5_act",    32'(o_act),   0);
        drive(2'b00, 6'd0, 6'd0, 1'b1, 6'd3, 1'b0, 6'd0, 1'b0);
        chk("tp5_rmiss", 32'(o_rmiss), 1);

        // reset in the second restore cycle
        drive(2'b11, 6'd30, 6'd31, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd30, 1'b0);
        idle();
        @(negedge clk);
        br_val_id = 2'b00;
        mispredict_val = 1'b0;
        chk("tp6_act_pre", 32'(restore_act), 1);
        rst = 1'b0;
        #1;
        chk("tp6_act_rst", 32'(restore_act), 0);
        chk("tp6_cnt_rst", 32'(ckpt_cnt),    0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // flush beats mispredict and allocation
        drive(2'b11, 6'd50, 6'd51, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        drive(2'b11, 6'd52, 6'd53, 1'b1, 6'd50, 1'b1, 6'd50, 1'b1);
        chk("tp6_fstall", 32'(o_stall), 1);
        chk("tp6_fen",    32'(o_en),    0);
        idle();
        chk("tp6_fcnt",   32'(o_cnt),   0);
        chk("tp6_fact",   32'(o_act),   0);
        idle();
        chk("tp6_fdone",  32'(o_done),  0);

        // randomized run against the queue model
        nxt_rob = 0;
        for (int c = 0; c < 3000; c++) begin
            bv = 2'($urandom_range(0, 3));
            r0 = 6'(nxt_rob);
            r1 = 6'(nxt_rob + 1);
            nxt_rob = (nxt_rob + 2) % 64;
            rv = ($urandom_range(0, 2) == 0);
            if (q_rob.size() > 0 && $urandom_range(0, 3) != 0) rr = 6'(q_rob[0]);
            else rr = 6'($urandom_range(0, 63));
            mv = ($urandom_range(0, 11) == 0);
            if (q_rob.size() > 0 && $urandom_range(0, 3) != 0) begin
                mr = 6'(q_rob[$urandom_range(0, q_rob.size() - 1)]);
            end else begin
                mr = 6'($urandom_range(0, 63));
                for (int t = 0; t < 8; t++) begin
                    found = 1'b0;
                    foreach (q_rob[j]) if (q_rob[j] == int'(mr)) found = 1'b1;
                    if (found) mr = mr + 6'd7;
                end
            end
            fl = ($urandom_range(0, 79) == 0);
            drive(bv, r0, r1, rv, rr, mv, mr, fl);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
